script_loader: RTL

Byte-to-instruction assembler that fills the 16-bit script memory later consumed by the script decoder. It sits between the UART byte receiver and the script RAM, and is active only while `script_mode` is 1 (load mode). It packs incoming bytes little-endian into instruction words and writes them at consecutive addresses starting from 0. It reports the loaded length and completion to the decoder side so execution can start at pc 0.

---
 rtl/script_pkg.sv | 47 ++++
 rtl/script_loader_if.sv | 35 +++
 rtl/byte_pair_packer.sv | 41 ++++
 rtl/script_loader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/script_pkg.sv
// -----------------------------------------------------------------------------
// script_pkg
// Shared definitions for the script loader / script decoder pair.
//   - opcode constants of the 16-bit instruction word
//   - bit positions of the instruction word fields
//       {i_num[15:8], i_sign[7:5], fun[4:3], op_code[2:0]}
//   - loader FSM state enum
//   - instr_valid(): opcode/fun legality rule used by the optional
//     content check (SCRIPT_LOADER_OPCHECK_EN)
// -----------------------------------------------------------------------------
package script_pkg;

   localparam logic [2:0] OP_ACTION = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_WAIT   = 3'b011;
   localparam logic [2:0] OP_STATE  = 3'b100;

   localparam int OPC_LSB  = 0;
   localparam int OPC_MSB  = 2;
   localparam int FUN_LSB  = 3;
   localparam int FUN_MSB  = 4;
   localparam int SIGN_MSB = 7;
   localparam int INUM_LSB = 8;
   localparam int INUM_MSB = 15;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOW   = 3'd1,
      ST_HIGH  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } loader_state_e;

   // ACTION accepts any fun; JUMP/WAIT/STATE only use fun 00/01.
   function automatic logic instr_valid(input logic [15:0] word);
      logic [2:0] op;
      logic [1:0] fn;
      op = word[OPC_MSB:OPC_LSB];
      fn = word[FUN_MSB:FUN_LSB];
      case (op)
         OP_ACTION:                  instr_valid = 1'b1;
         OP_JUMP, OP_WAIT, OP_STATE: instr_valid = (fn == 2'b00) || (fn == 2'b01);
         default:                    instr_valid = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/script_loader_if.sv
// -----------------------------------------------------------------------------
// script_loader_if
// Byte-in / word-out bus of the script loader.
//   rx_valid, rx_data : received byte strobe and byte (UART side)
//   wr_en, wr_addr,
//   wr_data           : script RAM write port
// Modports:
//   master : byte source / RAM observer (drives rx_*)
//   slave  : script_loader (drives wr_*)
// -----------------------------------------------------------------------------
interface script_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;

   modport master (
      output rx_valid,
      output rx_data,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );

   modport slave (
      input  rx_valid,
      input  rx_data,
      output wr_en,
      output wr_addr,
      output wr_data
   );
endinterface

// File: rtl/byte_pair_packer.sv
// -----------------------------------------------------------------------------
// byte_pair_packer
// Little-endian byte pair latch for the script loader.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_lo_en      : latch i_byte into o_word[7:0]
//   i_hi_en      : latch i_byte into o_word[15:8]
//   i_byte       : received byte
//   o_word       : assembled instruction word (held between loads)
//   o_word_vld   : one-cycle strobe, the cycle after the high byte is latched
// -----------------------------------------------------------------------------
module byte_pair_packer
   import script_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_lo_en,
   input  logic        i_hi_en,
   input  logic [7:0]  i_byte,
   output logic [15:0] o_word,
   output logic        o_word_vld
);

   logic [15:0] r_word_p0;
   logic        r_vld_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_p0 <= '0;
         r_vld_p0  <= 1'b0;
      end else begin
         r_vld_p0 <= i_hi_en;
         if (i_lo_en) r_word_p0[SIGN_MSB:OPC_LSB]  <= i_byte;
         if (i_hi_en) r_word_p0[INUM_MSB:INUM_LSB] <= i_byte;
      end
   end

   assign o_word     = r_word_p0;
   assign o_word_vld = r_vld_p0;

endmodule

// File: rtl/script_loader.sv
// -----------------------------------------------------------------------------
// script_loader
// Packs UART bytes (little-endian pairs) into 16-bit script instructions and
// writes them to the script RAM at consecutive addresses from 0 while
// script_mode is high.
// Parameters:
//   ADDR_W : script RAM address width (default 8)
//   DEPTH  : maximum instruction count, DEPTH <= 2**ADDR_W (default 256)
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   script_mode  : 1 = load mode; rising edge starts, falling edge ends a load
//   bus (slave)  : rx_valid/rx_data in, wr_en/wr_addr/wr_data out
//   script_len   : instructions written in the current/last load (saturates)
//   load_done    : level, clean load finished
//   load_err     : sticky per load: overflow, odd byte count, bad opcode
// Build option:
//   SCRIPT_LOADER_OPCHECK_EN : flag illegal op_code/fun combinations
//                              (the word is still written)
// -----------------------------------------------------------------------------
module script_loader
   import script_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              script_mode,
   script_loader_if.slave    bus,
   output logic [ADDR_W:0]   script_len,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   loader_state_e     r_state, w_state_nxt;
   logic              r_mode_p0, r_mode_p1;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_load_done, r_load_err, r_end_pend;

   logic              w_rise, w_fall, w_rx, w_start;
   logic [ADDR_W:0]   w_len_eff;
   logic              w_full, w_lo_acc, w_hi_acc, w_ovf;
   logic              w_odd_end, w_op_bad, w_err_set, w_to_done;
   logic [15:0]       w_word;
   logic              w_word_vld;

   // Mode is registered twice; edges come from the registered copies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_p0 <= 1'b0;
         r_mode_p1 <= 1'b0;
      end else begin
         r_mode_p0 <= script_mode;
         r_mode_p1 <= r_mode_p0;
      end
   end

   assign w_rise  = r_mode_p0 & ~r_mode_p1;
   assign w_fall  = ~r_mode_p0 & r_mode_p1;
   // Bytes are ignored as soon as the raw mode input drops.
   assign w_rx    = bus.rx_valid & script_mode;
   assign w_start = w_rise & ((r_state == ST_IDLE) | (r_state == ST_DONE));

   // A low byte arriving during WRITE must see the count that write produces.
   assign w_len_eff = (r_state == ST_WRITE) ? (r_len + LEN_ONE) : r_len;
   assign w_full    = (w_len_eff >= LEN_MAX);

   assign w_lo_acc  = w_rx & ~w_full & ((r_state == ST_LOW) | (r_state == ST_WRITE));
   assign w_ovf     = w_rx &  w_full & ((r_state == ST_LOW) | (r_state == ST_WRITE));
   assign w_hi_acc  = w_rx & (r_state == ST_HIGH);
   assign w_odd_end = (r_state == ST_HIGH) & w_fall;

`ifdef SCRIPT_LOADER_OPCHECK_EN
   assign w_op_bad = (r_state == ST_WRITE) & ~instr_valid(w_word);
`else
   assign w_op_bad = 1'b0;
`endif

   assign w_err_set = w_ovf | w_odd_end | w_op_bad;
   assign w_to_done = (r_state != ST_DONE) & (w_state_nxt == ST_DONE);

   byte_pair_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_lo_en    (w_lo_acc),
      .i_hi_en    (w_hi_acc),
      .i_byte     (bus.rx_data),
      .o_word     (w_word),
      .o_word_vld (w_word_vld)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (w_rise) w_state_nxt = ST_LOW;
         ST_LOW: begin
            if (w_fall | r_end_pend) w_state_nxt = ST_DONE;
            else if (w_lo_acc)       w_state_nxt = ST_HIGH;
         end
         ST_HIGH: begin
            if (w_fall)        w_state_nxt = ST_DONE;
            else if (w_hi_acc) w_state_nxt = ST_WRITE;
         end
         // The write always completes; an end request seen here is parked in
         // r_end_pend and honoured from LOW on the following cycle.
         ST_WRITE: begin
            if (w_lo_acc) w_state_nxt = ST_HIGH;
            else          w_state_nxt = ST_LOW;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Counters and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len       <= '0;
         r_wr_addr   <= '0;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
         r_end_pend  <= 1'b0;
      end else if (w_start) begin
         r_len       <= '0;
         r_wr_addr   <= '0;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
         r_end_pend  <= 1'b0;
      end else begin
         if (r_state == ST_WRITE) begin
            if (r_len < LEN_MAX)        r_len     <= r_len + LEN_ONE;
            if (r_wr_addr != '1)        r_wr_addr <= r_wr_addr + ADDR_ONE;
            if (w_fall)                 r_end_pend <= 1'b1;
         end
         if (w_err_set) r_load_err <= 1'b1;
         if (w_to_done) begin
            r_load_done <= ~(r_load_err | w_err_set);
            r_end_pend  <= 1'b0;
         end
      end
   end

   // Outputs
   always_comb begin
      bus.wr_en   = (r_state == ST_WRITE) & w_word_vld;
      bus.wr_addr = r_wr_addr;
      bus.wr_data = w_word;
      script_len  = r_len;
      load_done   = r_load_done;
      load_err    = r_load_err;
   end

endmodule
